// File: rtl/mips_mem_dump_pkg.sv
// Shared definitions for the MIPS32 data-memory dump engine.
//   - default widths for data, address and word count
//   - FSM state encoding used by mips_mem_dump
package mips_mem_dump_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 10;
    localparam int CNT_W_DEF  = 11;   // one wider than ADDR_W so a full 2**ADDR_W dump fits

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_HALT = 3'd1,
        S_READ      = 3'd2,
        S_CAPTURE   = 3'd3,
        S_SEND      = 3'd4,
        S_DONE      = 3'd5
    } state_e;

endpackage

// File: rtl/mips_mem_dump_if.sv
// Bus bundle for the memory dump engine.
//   control : start, start_addr, word_count, halted (in) / busy, done (out)
//   memory  : mem_rd_en, mem_addr (out) / mem_rdata (in, 1 cycle after rd_en)
//   stream  : out_valid, out_addr, out_data (out) / out_ready (in)
// slave  = the dump engine side, master = the environment driving it.
interface mips_mem_dump_if
    import mips_mem_dump_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [CNT_W-1:0]  word_count;
    logic              halted;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              done;

    modport slave (
        input  start, start_addr, word_count, halted, mem_rdata, out_ready,
        output mem_rd_en, mem_addr, out_valid, out_addr, out_data, busy, done
    );

    modport master (
        output start, start_addr, word_count, halted, mem_rdata, out_ready,
        input  mem_rd_en, mem_addr, out_valid, out_addr, out_data, busy, done
    );

endinterface

// File: rtl/mips_mem_dump.sv
// Read-back engine for the pipelined MIPS32 data memory.
// Waits for the core to halt, then reads word_count words starting at
// start_addr (wrapping modulo 2**ADDR_W) one at a time and streams each
// {address, data} pair out over a valid/ready port. One word in flight at
// most: READ -> CAPTURE -> SEND, 3 cycles per word with out_ready high.
// Ports:
//   clk1  : single clock, all logic on its rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mips_mem_dump_if.slave (control, memory read, output stream)
module mips_mem_dump
    import mips_mem_dump_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic            clk1,
    input  logic            rst_n,
    mips_mem_dump_if.slave  bus
);

    state_e            state_q,     state_d;
    logic [ADDR_W-1:0] cur_addr_q,  cur_addr_d;
    logic [CNT_W-1:0]  count_q,     count_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        case (state_q)
            S_IDLE: begin
                // Window is latched here; later changes on the inputs are ignored.
                if (bus.start) begin
                    cur_addr_d = bus.start_addr;
                    count_d    = bus.word_count;
                    state_d    = S_WAIT_HALT;
                end
            end
            S_WAIT_HALT: begin
                if (bus.halted) begin
                    state_d = (count_q == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                // mem_rdata is valid exactly one cycle after the READ strobe.
                out_data_d  = bus.mem_rdata;
                out_addr_d  = cur_addr_q;
                out_valid_d = 1'b1;
                state_d     = S_SEND;
            end
            S_SEND: begin
                // out_* stay frozen until the sink takes the word.
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    cur_addr_d  = cur_addr_q + ADDR_W'(1);
                    count_d     = count_q - CNT_W'(1);
                    state_d     = (count_q == CNT_W'(1)) ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.mem_rd_en = (state_q == S_READ);
    assign bus.mem_addr  = (state_q == S_READ) ? cur_addr_q : '0;
    assign bus.out_valid = out_valid_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);

endmodule

// File: tb/tb_mips_mem_dump.sv
// Self-checking bench for mips_mem_dump: a behavioural memory plus an
// expected-word queue built from the dump window with modulo arithmetic.
module tb_mips_mem_dump;

    logic clk1;
    logic rst_n;

    mips_mem_dump_if #(.DATA_W(32), .ADDR_W(10), .CNT_W(11)) bus ();

    mips_mem_dump #(.DATA_W(32), .ADDR_W(10), .CNT_W(11)) dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic [31:0] mem [1024];

    // Read data appears one cycle after the strobe; otherwise it is garbage.
    always @(posedge clk1) begin
        if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
        else               bus.mem_rdata <= $urandom;
    end

    int vectors;
    int miscompares;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: out_ready always 1; mode 1: random ready and halted dropped
    // mid-dump; mode 2: 7-cycle stall on word 1.
    task automatic run_dump(input int sa, input int cnt, input int hd, input int mode);
        logic [9:0]  exp_a [$];
        logic [31:0] exp_d [$];
        logic [9:0]  rd_a  [$];
        logic [63:0] e;
        int cyc, widx, stall;
        bit seen_done, rdy;
        for (int i = 0; i < cnt; i++) begin
            exp_a.push_back(10'((sa + i) % 1024));
            exp_d.push_back(mem[(sa + i) % 1024]);
            rd_a.push_back(10'((sa + i) % 1024));
        end
        @(negedge clk1);
        bus.halted     = (hd == 0);
        bus.start      = 1'b1;
        bus.start_addr = 10'(sa);
        bus.word_count = 11'(cnt);
        bus.out_ready  = 1'b0;
        cyc = 0; widx = 0; stall = 0; seen_done = 1'b0;
        while (!seen_done && cyc < 4000) begin
            @(negedge clk1);
            cyc++;
            if (cyc == 1) begin
                bus.start      = 1'b0;
                bus.start_addr = 10'($urandom);
                bus.word_count = 11'($urandom);
                check("busy_after_start", 64'(bus.busy), 64'd1);
            end
            if (hd > 0 && cyc <= hd) check("no_rd_before_halt", 64'(bus.mem_rd_en), 64'd0);
            if (hd > 0 && cnt > 0 && cyc == hd + 1) check("rd_after_halt", 64'(bus.mem_rd_en), 64'd1);
            if (bus.mem_rd_en) begin
                e = (rd_a.size() > 0) ? 64'(rd_a[0]) : 64'hFFFF_FFFF;
                if (rd_a.size() > 0) void'(rd_a.pop_front());
                check("mem_addr", 64'(bus.mem_addr), e);
            end else begin
                check("mem_addr_idle", 64'(bus.mem_addr), 64'd0);
            end
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = ($urandom_range(0, 2) != 0);
            else if (widx == 1 && bus.out_valid && stall < 7) begin rdy = 1'b0; stall++; end
            else                rdy = 1'b1;
            bus.out_ready = rdy;
            if (bus.out_valid) begin
                check("out_addr", 64'(bus.out_addr), (exp_a.size() > 0) ? 64'(exp_a[0]) : 64'hFFFF_FFFF);
                check("out_data", 64'(bus.out_data), (exp_d.size() > 0) ? 64'(exp_d[0]) : 64'hFFFF_FFFF_FFFF);
                if (rdy && exp_a.size() > 0) begin
                    void'(exp_a.pop_front());
                    void'(exp_d.pop_front());
                    widx++;
                end
            end
            if (bus.done) begin
                seen_done = 1'b1;
                check("done_drained", 64'(exp_a.size()), 64'd0);
                if (mode == 0 && hd == 0) check("done_latency", 64'(cyc), 64'(2 + 3 * cnt));
            end
            if (hd > 0 && cyc == hd) bus.halted = 1'b1;
            if (mode == 1 && widx > 0) bus.halted = 1'b0;
        end
        check("dump_finished", 64'(seen_done), 64'd1);
        if (mode == 2) check("stall_cycles", 64'(stall), 64'd7);
        @(negedge clk1);
        check("done_one_pulse", 64'(bus.done), 64'd0);
        check("idle_busy", 64'(bus.busy), 64'd0);
        check("idle_valid", 64'(bus.out_valid), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  64'(bus.busy),      64'd0);
        check({tag, "_done"},  64'(bus.done),      64'd0);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_oaddr"}, 64'(bus.out_addr),  64'd0);
        check({tag, "_odata"}, 64'(bus.out_data),  64'd0);
        check({tag, "_rden"},  64'(bus.mem_rd_en), 64'd0);
        check({tag, "_maddr"}, 64'(bus.mem_addr),  64'd0);
    endtask

    initial begin
        int got_valid;
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[120] = 32'd40;
        mem[121] = 32'd30;

        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.word_count = '0;
        bus.halted     = 1'b0;
        bus.out_ready  = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk1);
        rst_n = 1'b1;

        run_dump(120, 2, 10, 0);    // Mem[120]=40, Mem[121]=30
        run_dump(300, 0, 0, 0);     // empty window
        run_dump(int'($urandom_range(0, 1023)), 3, 50, 0);
        run_dump(int'($urandom_range(0, 1023)), 3, 0, 2);
        run_dump(1023, 3, 0, 0);    // wraps 1023, 0, 1
        run_dump(1022, 4, 2, 1);

        // Reset in the middle of SEND with a word presented.
        @(negedge clk1);
        bus.halted = 1'b1; bus.start = 1'b1;
        bus.start_addr = 10'd500; bus.word_count = 11'd3; bus.out_ready = 1'b0;
        @(negedge clk1);
        bus.start = 1'b0;
        got_valid = 0;
        for (int i = 0; i < 20 && got_valid == 0; i++) begin
            @(negedge clk1);
            if (bus.out_valid) got_valid = 1;
        end
        check("rst_pre_valid", 64'(got_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midrst");
        @(negedge clk1);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk1);
            check("post_rst_no_done", 64'(bus.done), 64'd0);
        end
        run_dump(7, 4, 0, 0);

        for (int t = 0; t < 4; t++)
            run_dump(int'($urandom_range(0, 1023)), int'($urandom_range(1, 6)),
                     int'($urandom_range(0, 5)), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
